// File: rtl/bcd2bin_pkg.sv
// bcd2bin_pkg: shared sizes, FSM encoding and BCD validity helper for bcd2bin_ctrl.
// BCD2BIN_CHECK_EN adds the BAD state and the digit validity check.
package bcd2bin_pkg;
    localparam int N_DIGITS = 5;
    localparam int N_SHIFTS = 16;
    localparam int BCD_W    = 20;
    localparam int BIN_W    = 16;
    localparam int REG_W    = 36;
`ifdef BCD2BIN_CHECK_EN
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CORR, FIN, BAD} state_t;
    function automatic logic bcd_bad(input logic [BCD_W-1:0] b);
        bcd_bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) bcd_bad |= (b[4*i+:4] > 4'd9);
    endfunction
`else
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CORR, FIN} state_t;
`endif
endpackage

// File: rtl/bcd_digit_corr.sv
// bcd_digit_corr: subtracts 3 from every BCD digit that reached 8 or more after a right shift.
module bcd_digit_corr
    import bcd2bin_pkg::*;
(
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q
);
    for (genvar g = 0; g < N_DIGITS; g++) begin : gen_d
        assign q[4*g+:4] = (d[4*g+:4] >= 4'd8) ? d[4*g+:4] - 4'd3 : d[4*g+:4];
    end
endmodule

// File: rtl/bcd2bin_ctrl.sv
// bcd2bin_ctrl: shift-and-correct BCD-to-binary controller driving an external 36-bit register.
// BCD2BIN_CHECK_EN enables invalid-digit and overflow detection via err.
module bcd2bin_ctrl
    import bcd2bin_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BCD_W-1:0] bcd_in,
    input  logic [REG_W-1:0] A,
    output logic             init,
    output logic             sh,
    output logic             sub,
    output logic [BCD_W-1:0] bcd,
    output logic [REG_W-1:0] A_in,
    output logic             busy,
    output logic             done,
    output logic [BIN_W-1:0] bin,
    output logic             err
);
    state_t     state;
    logic [4:0] cnt;
    logic [BCD_W-1:0] corr;

    bcd_digit_corr u_corr (.d(A[REG_W-1:BIN_W]), .q(corr));
    assign A_in = {corr, A[BIN_W-1:0]};

`ifndef BCD2BIN_CHECK_EN
    assign err = 1'b0;
`endif

    // bcd doubles as the capture register; strobes are set on entry to their state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            bcd   <= '0;
            init  <= 1'b0;
            sh    <= 1'b0;
            sub   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bin   <= '0;
`ifdef BCD2BIN_CHECK_EN
            err   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    bcd  <= bcd_in;
                    cnt  <= '0;
                    busy <= 1'b1;
`ifdef BCD2BIN_CHECK_EN
                    if (bcd_bad(bcd_in)) state <= BAD;
                    else begin
                        state <= LOAD;
                        init  <= 1'b1;
                    end
`else
                    state <= LOAD;
                    init  <= 1'b1;
`endif
                end
                LOAD: begin
                    init  <= 1'b0;
                    sh    <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: begin
                    sh  <= 1'b0;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(N_SHIFTS - 1)) state <= FIN;
                    else begin
                        sub   <= 1'b1;
                        state <= CORR;
                    end
                end
                CORR: begin
                    sub   <= 1'b0;
                    sh    <= 1'b1;
                    state <= SHIFT;
                end
                FIN: begin
                    bin   <= A[BIN_W-1:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef BCD2BIN_CHECK_EN
                    err   <= |A[REG_W-1:BIN_W];
`endif
                end
`ifdef BCD2BIN_CHECK_EN
                BAD: begin
                    bin   <= '0;
                    err   <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd2bin_ctrl.sv
// tb_bcd2bin_ctrl: pairs bcd2bin_ctrl with a 36-bit shift register and checks it against decimal arithmetic.
module tb_bcd2bin_ctrl;
`ifdef BCD2BIN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    // done lands 33 edges after the sampling edge, i.e. the 34th edge counting that edge itself
    localparam int LAT = 33;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [19:0] bcd_in = '0, bcd;
    logic [35:0] A, A_in;
    logic        init, sh, sub, busy, done, err;
    logic [15:0] bin;

    int compared = 0, mismatched = 0;
    int ecount = 0, e0, lat, n_init, n_sh, n_sub, n_excl;

    bcd2bin_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in), .A(A),
        .init(init), .sh(sh), .sub(sub), .bcd(bcd), .A_in(A_in),
        .busy(busy), .done(done), .bin(bin), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    always @(posedge clk or posedge rst)
        if (rst) A <= '0;
        else if (init) A <= {bcd, 16'h0000};
        else if (sh) A <= A >> 1;
        else if (sub) A <= A_in;

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] b;
        int r;
        b = '0;
        r = v;
        for (int i = 0; i < 5; i++) begin
            b[4*i+:4] = 4'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [19:0] b, input int pulse_at, input int rst_at);
        int n;
        logic aborted;
        start = 1'b1;
        bcd_in = b;
        @(negedge clk);
        e0 = ecount;
        start = 1'b0;
        {n_init, n_sh, n_sub, n_excl} = '0;
        n = 0;
        aborted = 1'b0;
        while (!done && n < 100) begin
            n_init += int'(init);
            n_sh += int'(sh);
            n_sub += int'(sub);
            if (int'(init) + int'(sh) + int'(sub) > 1) n_excl++;
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                check("busy_after_rst", {35'd0, busy}, 36'd0);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (n == pulse_at) begin
                start = 1'b1;
                bcd_in = 20'h54321;
            end else start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!aborted) begin
            check("done_seen", {35'd0, done}, 36'd1);
            lat = ecount - e0;
        end
    endtask

    task automatic verify(input string tag, input logic [19:0] b, input logic [15:0] eb,
                          input logic ee, input logic bad);
        run(b, -1, -1);
        check({tag, "_bin"}, {20'd0, bin}, {20'd0, eb});
        check({tag, "_err"}, {35'd0, err}, {35'd0, ee});
        check({tag, "_lat"}, 36'(lat), bad ? 36'd1 : 36'(LAT));
        check({tag, "_init"}, 36'(n_init), bad ? 36'd0 : 36'd1);
        check({tag, "_sh"}, 36'(n_sh), bad ? 36'd0 : 36'd16);
        check({tag, "_sub"}, 36'(n_sub), bad ? 36'd0 : 36'd15);
        check({tag, "_excl"}, 36'(n_excl), 36'd0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            nd += int'(done);
        end
        check(tag, 36'(nd), 36'd0);
    endtask

    initial begin
        int v, k, n;
        int d[3];
        repeat (2) @(negedge clk);
        check("rst_busy", {35'd0, busy}, 36'd0);
        check("rst_done", {35'd0, done}, 36'd0);
        check("rst_bin", {20'd0, bin}, 36'd0);
        check("rst_err", {35'd0, err}, 36'd0);
        check("rst_strobes", {33'd0, init, sh, sub}, 36'd0);
        check("rst_bcd", {16'd0, bcd}, 36'd0);
        rst = 1'b0;
        @(negedge clk);

        verify("c12345", 20'h12345, 16'h3039, 1'b0, 1'b0);
        verify("c65535", 20'h65535, 16'hFFFF, 1'b0, 1'b0);
        verify("c00000", 20'h00000, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, 99999));
            verify("rand", to_bcd(v), 16'(v % 65536), CHK && v > 65535, 1'b0);
        end
`ifdef BCD2BIN_CHECK_EN
        verify("c65536", 20'h65536, 16'h0000, 1'b1, 1'b0);
        verify("c1A000", 20'h1A000, 16'h0000, 1'b1, 1'b1);
`endif

        run(20'h12345, 9, -1);
        check("repulse_bin", {20'd0, bin}, 36'h3039);
        check("repulse_lat", 36'(lat), 36'(LAT));
        quiet("repulse_extra_done", 40);
        check("repulse_hold_bin", {20'd0, bin}, 36'h3039);

        run(20'h98765, -1, 19);
        quiet("rst_abort_done", 40);
        check("rst_abort_bin", {20'd0, bin}, 36'd0);
        verify("after_rst", 20'h12345, 16'h3039, 1'b0, 1'b0);

        // start held high: each done is followed one edge later by a new capture
        bcd_in = 20'h00042;
        start = 1'b1;
        k = 0;
        n = 0;
        while (k < 3 && n < 300) begin
            @(negedge clk);
            n++;
            if (done) begin
                d[k] = ecount;
                k++;
                check("b2b_bin", {20'd0, bin}, 36'd42);
            end
        end
        start = 1'b0;
        check("b2b_count", 36'(k), 36'd3);
        check("b2b_gap1", 36'(d[1] - d[0]), 36'(LAT + 1));
        check("b2b_gap2", 36'(d[2] - d[1]), 36'(LAT + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
